// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues DIV/REM ops to a multi-cycle divider, stalls the pipe, writes back, caches the last result
//   ex_*        : EX-stage instruction (req = ex_valid & ex_is_div), flush kills it
//   pipe_stall  : hold front of pipeline while a divide is pending
//   wb_*        : one-cycle writeback strobe with register, data and timeout flag
//   err_timeout : sticky, set when the divider never answers within TIMEOUT cycles
//   div_*       : start pulse / registered operands out, busy / done / result in
module div_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int REGW    = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_div,
  input  logic [1:0]       ex_op,
  input  logic [WIDTH-1:0] ex_a,
  input  logic [WIDTH-1:0] ex_b,
  input  logic [REGW-1:0]  ex_rd,
  input  logic             flush,
  output logic             pipe_stall,
  output logic             wb_valid,
  output logic [REGW-1:0]  wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_err,
  output logic             err_timeout,
  output logic             div_start,
  output logic [1:0]       div_op,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_result
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, WB} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [REGW-1:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d, a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] ca_q, ca_d, cb_q, cb_d, cr_q, cr_d;
  logic [1:0] op_q, op_d, cop_q, cop_d;
  logic wb_err_q, wb_err_d, err_q, err_d, cv_q, cv_d;
  logic req, hit;
  assign req = ex_valid & ex_is_div;
  assign hit = cv_q & (cop_q == ex_op) & (ca_q == ex_a) & (cb_q == ex_b);
  assign wb_rd = wb_rd_q;
  assign wb_data = wb_data_q;
  assign wb_err = wb_err_q;
  assign err_timeout = err_q;
  assign div_op = op_q;
  assign div_a = a_q;
  assign div_b = b_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    wb_rd_d = wb_rd_q;
    wb_data_d = wb_data_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    wb_err_d = wb_err_q;
    err_d = err_q;
    cv_d = cv_q;
    cop_d = cop_q;
    ca_d = ca_q;
    cb_d = cb_q;
    cr_d = cr_q;
    pipe_stall = 1'b0;
    wb_valid = 1'b0;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        pipe_stall = req & !flush;
        if (req & !flush) begin
          op_d = ex_op;
          a_d = ex_a;
          b_d = ex_b;
          rd_d = ex_rd;
          state_d = hit ? WB : ISSUE;
          if (hit) begin
            wb_data_d = cr_q;
            wb_rd_d = ex_rd;
            wb_err_d = 1'b0;
          end
        end
      end
      ISSUE: begin
        pipe_stall = !flush;
        div_start = !div_busy & !flush;
        if (flush) state_d = IDLE;
        else if (!div_busy) begin
          state_d = WAIT;
          cnt_d = '0;
        end
      end
      WAIT: begin
        pipe_stall = !flush;
        if (div_done) begin
          state_d = flush ? IDLE : WB;
          if (!flush) begin
            wb_data_d = div_result;
            wb_rd_d = rd_q;
            wb_err_d = 1'b0;
            cv_d = 1'b1;
            cop_d = op_q;
            ca_d = a_q;
            cb_d = b_q;
            cr_d = div_result;
          end
        end else if (flush) state_d = DRAIN;
        else if (cnt_q == LAST) begin
          state_d = WB;
          err_d = 1'b1;
          wb_err_d = 1'b1;
          wb_data_d = '1;
          wb_rd_d = rd_q;
          cv_d = 1'b0;
        end else cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end
      DRAIN: begin
        pipe_stall = req & !flush;
        if (div_done) state_d = IDLE;
      end
      WB: begin
        wb_valid = !flush;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      pipe_stall = 1'b0;
      wb_valid = 1'b0;
      div_start = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_q <= '0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      wb_err_q <= 1'b0;
      err_q <= 1'b0;
      cv_q <= 1'b0;
      cop_q <= '0;
      ca_q <= '0;
      cb_q <= '0;
      cr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      wb_err_q <= wb_err_d;
      err_q <= err_d;
      cv_q <= cv_d;
      cop_q <= cop_d;
      ca_q <= ca_d;
      cb_q <= cb_d;
      cr_q <= cr_d;
    end
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic ex_valid = 1'b0, ex_is_div = 1'b0, flush = 1'b0;
  logic [1:0] ex_op = '0;
  logic [31:0] ex_a = '0, ex_b = '0, div_result = '0;
  logic [4:0] ex_rd = '0;
  logic div_busy = 1'b0, div_done = 1'b0;
  logic pipe_stall, wb_valid, wb_err, err_timeout, div_start;
  logic [4:0] wb_rd;
  logic [31:0] wb_data, div_a, div_b;
  logic [1:0] div_op;
  int checks = 0, failures = 0, starts = 0;
  div_issue_ctrl #(.WIDTH(32), .REGW(5), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_div(ex_is_div), .ex_op(ex_op),
    .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd), .flush(flush), .pipe_stall(pipe_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err),
    .err_timeout(err_timeout), .div_start(div_start), .div_op(div_op), .div_a(div_a),
    .div_b(div_b), .div_busy(div_busy), .div_done(div_done), .div_result(div_result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (div_start) starts <= starts + 1;
  task tick;
    @(posedge clk);
    #1;
  endtask
  task issue_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                input logic [4:0] rd, input int busy_n, input int wait_n, input logic [31:0] res);
    int s0;
    ex_valid = 1; ex_is_div = 1; ex_op = op; ex_a = a; ex_b = b; ex_rd = rd; #1;
    checks++; if (pipe_stall !== 1'b1) begin failures++; $display("FAIL idle_stall got=%b exp=1", pipe_stall); end
    tick;
    s0 = starts;
    div_busy = 1;
    for (int i = 0; i < busy_n; i++) begin
      #1;
      checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL busy_nostart got=%b exp=0", div_start); end
      checks++; if (pipe_stall !== 1'b1) begin failures++; $display("FAIL busy_stall got=%b exp=1", pipe_stall); end
      tick;
    end
    div_busy = 0; #1;
    checks++; if (div_start !== 1'b1) begin failures++; $display("FAIL issue_start got=%b exp=1", div_start); end
    checks++; if ({div_op, div_a, div_b} !== {op, a, b}) begin failures++; $display("FAIL issue_operands got=%h/%h/%h exp=%h/%h/%h", div_op, div_a, div_b, op, a, b); end
    tick;
    for (int i = 0; i < wait_n; i++) begin
      #1;
      checks++; if ({div_start, pipe_stall, wb_valid} !== 3'b010) begin failures++; $display("FAIL wait_outputs got=%b exp=010", {div_start, pipe_stall, wb_valid}); end
      tick;
    end
    div_done = 1; div_result = res; #1;
    checks++; if (pipe_stall !== 1'b1) begin failures++; $display("FAIL done_stall got=%b exp=1", pipe_stall); end
    tick;
    div_done = 0; #1;
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL wb_valid got=%b exp=1", wb_valid); end
    checks++; if (wb_data !== res) begin failures++; $display("FAIL wb_data got=%h exp=%h", wb_data, res); end
    checks++; if (wb_rd !== rd) begin failures++; $display("FAIL wb_rd got=%0d exp=%0d", wb_rd, rd); end
    checks++; if ({wb_err, pipe_stall} !== 2'b00) begin failures++; $display("FAIL wb_err_stall got=%b exp=00", {wb_err, pipe_stall}); end
    checks++; if (starts - s0 !== 1) begin failures++; $display("FAIL start_count got=%0d exp=1", starts - s0); end
    tick;
    ex_valid = 0; #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL wb_one_cycle got=%b exp=0", wb_valid); end
    checks++; if (wb_data !== res) begin failures++; $display("FAIL wb_data_hold got=%h exp=%h", wb_data, res); end
  endtask
  task test_reset;
    rst = 1; ex_valid = 1; ex_is_div = 1; ex_a = 32'd77; ex_b = 32'd3;
    tick; tick; #1;
    checks++; if ({pipe_stall, wb_valid, wb_err, err_timeout, div_start} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {pipe_stall, wb_valid, wb_err, err_timeout, div_start}); end
    checks++; if ({wb_data, wb_rd, div_a, div_b, div_op} !== '0) begin failures++; $display("FAIL reset_regs got=%h/%h/%h/%h/%h exp=0", wb_data, wb_rd, div_a, div_b, div_op); end
    rst = 0; ex_valid = 0;
    tick;
  endtask
  task test_div_basic;
    issue_op(2'b00, 32'd100, 32'd7, 5'd3, 0, 33, 32'd14);
  endtask
  task test_cache;
    int s0;
    issue_op(2'b10, 32'd100, 32'd7, 5'd4, 0, 3, 32'd2);
    ex_valid = 1; ex_is_div = 1; ex_op = 2'b10; ex_a = 32'd100; ex_b = 32'd7; ex_rd = 5'd5; #1;
    s0 = starts;
    checks++; if ({pipe_stall, div_start} !== 2'b10) begin failures++; $display("FAIL hit_stall got=%b exp=10", {pipe_stall, div_start}); end
    tick;
    checks++; if ({wb_valid, pipe_stall} !== 2'b10) begin failures++; $display("FAIL hit_wb got=%b exp=10", {wb_valid, pipe_stall}); end
    checks++; if ({wb_data, wb_rd} !== {32'd2, 5'd5}) begin failures++; $display("FAIL hit_data got=%h/%0d exp=2/5", wb_data, wb_rd); end
    checks++; if (starts !== s0) begin failures++; $display("FAIL hit_no_start got=%0d exp=%0d", starts, s0); end
    tick;
    ex_valid = 0;
  endtask
  task test_div_zero;
    issue_op(2'b00, 32'd5, 32'd0, 5'd2, 0, 1, 32'hFFFF_FFFF);
  endtask
  task test_flush_drain;
    ex_valid = 1; ex_is_div = 1; ex_op = 2'b00; ex_a = 32'd50; ex_b = 32'd5; ex_rd = 5'd4;
    tick; tick; tick;
    for (int i = 0; i < 4; i++) tick;
    flush = 1; #1;
    checks++; if ({pipe_stall, wb_valid} !== 2'b00) begin failures++; $display("FAIL flush_stall got=%b exp=00", {pipe_stall, wb_valid}); end
    tick;
    flush = 0; ex_op = 2'b01; ex_a = 32'd9; ex_b = 32'd2; ex_rd = 5'd6;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if ({pipe_stall, wb_valid, div_start} !== 3'b100) begin failures++; $display("FAIL drain_outputs got=%b exp=100", {pipe_stall, wb_valid, div_start}); end
      tick;
    end
    div_done = 1; div_result = 32'd10; #1;
    tick;
    div_done = 0; #1;
    checks++; if ({wb_valid, pipe_stall, div_start} !== 3'b010) begin failures++; $display("FAIL drain_exit got=%b exp=010", {wb_valid, pipe_stall, div_start}); end
    checks++; if (wb_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL drain_no_wb got=%h exp=ffffffff", wb_data); end
    tick;
    checks++; if ({div_start, div_op, div_a} !== {1'b1, 2'b01, 32'd9}) begin failures++; $display("FAIL restart got=%b/%b/%0d exp=1/01/9", div_start, div_op, div_a); end
    tick;
    div_done = 1; div_result = 32'd4;
    tick;
    div_done = 0; #1;
    checks++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'd4, 5'd6}) begin failures++; $display("FAIL flush_new_wb got=%b/%0d/%0d exp=1/4/6", wb_valid, wb_data, wb_rd); end
    tick;
    ex_valid = 0;
  endtask
  task test_busy;
    issue_op(2'b00, 32'd20, 32'd3, 5'd8, 3, 2, 32'd6);
  endtask
  task test_timeout;
    ex_valid = 1; ex_is_div = 1; ex_op = 2'b00; ex_a = 32'd1; ex_b = 32'd1; ex_rd = 5'd7;
    tick; tick;
    for (int i = 0; i < 63; i++) begin
      #1;
      checks++; if ({wb_valid, pipe_stall} !== 2'b01) begin failures++; $display("FAIL to_wait cyc=%0d got=%b exp=01", i, {wb_valid, pipe_stall}); end
      tick;
    end
    #1;
    checks++; if (pipe_stall !== 1'b1) begin failures++; $display("FAIL to_last_stall got=%b exp=1", pipe_stall); end
    tick;
    checks++; if ({wb_valid, wb_err, err_timeout} !== 3'b111) begin failures++; $display("FAIL to_flags got=%b exp=111", {wb_valid, wb_err, err_timeout}); end
    checks++; if ({wb_data, wb_rd} !== {32'hFFFF_FFFF, 5'd7}) begin failures++; $display("FAIL to_data got=%h/%0d exp=ffffffff/7", wb_data, wb_rd); end
    tick;
    ex_valid = 0;
    tick;
    checks++; if ({wb_err, err_timeout, wb_valid} !== 3'b110) begin failures++; $display("FAIL to_sticky got=%b exp=110", {wb_err, err_timeout, wb_valid}); end
    issue_op(2'b01, 32'd9, 32'd2, 5'd6, 0, 0, 32'd4);
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky_after got=%b exp=1", err_timeout); end
  endtask
  task test_reset_mid_wait;
    ex_valid = 1; ex_is_div = 1; ex_op = 2'b00; ex_a = 32'd30; ex_b = 32'd6; ex_rd = 5'd9;
    tick; tick; tick; tick;
    rst = 1;
    tick;
    checks++; if ({pipe_stall, wb_err, err_timeout, div_start} !== 4'b0) begin failures++; $display("FAIL rst_wait_flags got=%b exp=0000", {pipe_stall, wb_err, err_timeout, div_start}); end
    checks++; if ({wb_data, div_a} !== '0) begin failures++; $display("FAIL rst_wait_regs got=%h/%h exp=0", wb_data, div_a); end
    rst = 0; ex_valid = 0; div_done = 1; div_result = 32'd5; #1;
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL stray_stall got=%b exp=0", pipe_stall); end
    tick;
    div_done = 0; #1;
    checks++; if ({wb_valid, wb_data} !== {1'b0, 32'd0}) begin failures++; $display("FAIL stray_done got=%b/%h exp=0/0", wb_valid, wb_data); end
    ex_valid = 1; ex_op = 2'b01; ex_a = 32'd9; ex_b = 32'd2; ex_rd = 5'd6;
    tick;
    checks++; if ({div_start, wb_valid} !== 2'b10) begin failures++; $display("FAIL cache_cleared got=%b exp=10", {div_start, wb_valid}); end
    ex_valid = 0;
    tick;
  endtask
  initial begin
    test_reset;
    test_div_basic;
    test_cache;
    test_div_zero;
    test_flush_drain;
    test_busy;
    test_timeout;
    test_reset_mid_wait;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter REGW, default 5, destination register index width.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles before abandoning a division.
REQ-004 SHALL have ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX-stage instruction valid
- ex_is_div  in  1  EX instruction is DIV/DIVU/REM/REMU
- ex_op  in  2  bit1 = remainder, bit0 = unsigned
- ex_a, ex_b  in  WIDTH  dividend, divisor
- ex_rd  in  REGW  destination register
- flush  in  1  pipeline flush, kills EX instruction
- pipe_stall  out  1  hold front of pipeline
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  REGW  writeback register
- wb_data  out  WIDTH  writeback value
- wb_err  out  1  writeback value came from timeout
- err_timeout  out  1  sticky timeout flag
- div_start  out  1  one-cycle start pulse to divider
- div_op  out  2  registered op
- div_a, div_b  out  WIDTH  registered operands
- div_busy  in  1  divider busy
- div_done  in  1  divider completion pulse
- div_result  in  WIDTH  divider result, valid while div_done=1

Function
REQ-005 SHALL define req = ex_valid & ex_is_div.
REQ-006 SHALL implement states IDLE, ISSUE, WAIT, DRAIN, WB.
REQ-007 IDLE: on req & !flush, SHALL register ex_op/ex_a/ex_b/ex_rd into div_op/div_a/div_b/rd latch. On cache hit (REQ-015) SHALL go to WB with the cached result; otherwise SHALL go to ISSUE.
REQ-008 ISSUE: div_start SHALL equal !div_busy & !flush. A started divide SHALL go to WAIT with the wait counter cleared. With div_busy=1 and no flush, SHALL stay in ISSUE. Flush SHALL go to IDLE without starting.
REQ-009 WAIT: div_done & !flush SHALL capture div_result into wb_data, update the cache, and go to WB.
- div_done & flush SHALL go to IDLE, discarding the result.
- flush without div_done SHALL go to DRAIN.
- Otherwise the counter SHALL increment. At counter == TIMEOUT-1 without div_done, SHALL set err_timeout and wb_err, load wb_data all-ones, and go to WB.
REQ-010 DRAIN: SHALL wait for div_done, then go to IDLE. No writeback, no cache update; flush has no effect.
REQ-011 WB: wb_valid SHALL equal !flush for exactly this cycle. State SHALL go to IDLE unconditionally. req SHALL be ignored in this cycle (same instruction).
REQ-012 pipe_stall SHALL equal !flush & ((IDLE & req & !hit-bypass-disabled) | ISSUE | WAIT | (DRAIN & req)). pipe_stall SHALL be 0 in WB.
REQ-013 div_start SHALL never be high for two consecutive cycles, and never outside ISSUE.
REQ-014 wb_rd SHALL be the latched ex_rd. wb_data/wb_rd SHALL hold their values outside WB.
REQ-015 Cache: one entry {valid, op, a, b, result}.
- hit = valid & all fields equal the current ex_op/ex_a/ex_b.
- Written only on normal WAIT completion.
- A timeout SHALL invalidate the cache.
- Hit latency: one stall cycle, then WB.
REQ-016 The wait counter SHALL be $clog2(TIMEOUT)+1 bits and SHALL saturate, never wrap.
REQ-017 div_done outside WAIT/DRAIN SHALL be ignored.
REQ-018 wb_err SHALL clear on the next WB without timeout.

Reset
REQ-019 rst SHALL dominate all inputs. State SHALL go to IDLE. These outputs SHALL be 0: pipe_stall, wb_valid, wb_err, err_timeout, div_start, wb_data, wb_rd, div_a, div_b, div_op. Cache valid SHALL be 0.
REQ-020 rst mid-WAIT SHALL abandon the operation. A later stray div_done SHALL be ignored per REQ-017.

Verification
REQ-021 DIV 100/7 rd=3, divider model done after 34 cycles -> single div_start, pipe_stall high until WB, then wb_valid=1, wb_rd=3, wb_data=14.
REQ-022 REM 100/7, then REM 100/7 again -> first via divider returns 2; second returns 2 after one stall cycle with no div_start.
REQ-023 DIV 5/0 with model returning 0xFFFFFFFF on done 2 cycles after start -> wb_data=0xFFFFFFFF, wb_valid one cycle.
REQ-024 flush 5 cycles into WAIT, new DIVU 9/2 presented -> DRAIN, pipe_stall=1, no wb_valid for the killed op. After done: IDLE, new start, wb_data=4.
REQ-025 model never asserts div_done, TIMEOUT=64 -> WB at cycle 64 of WAIT with wb_data=0xFFFFFFFF, wb_err=1, err_timeout=1 until rst.
REQ-026 div_busy=1 for 3 cycles in ISSUE -> div_start held low, then exactly one pulse when div_busy falls.
